// File: rtl/deconv_pkg.sv
// deconv_pkg
//   Shared types and sizing helpers for the N-kernel deconvolution scheduler.
//   - rd_state_e   : reader FSM states
//   - DEF_*        : default geometry (2x2 feature, 3x3 weight, 4 kernels)
//   - helpers      : counter widths, pixels/loads per channel, bus widths
package deconv_pkg;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_WAIT_BANK,
        RD_ISSUE,
        RD_STEP,
        RD_DONE
    } rd_state_e;

    // Minimum width 1 so single-entry counters still have a legal vector.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int pix_per_ch(input int sf);
        return sf * sf;
    endfunction

    function automatic int loads_per_ch(input int sf, input int sw);
        return sf * sw;
    endfunction

    function automatic int col_width(input int sf, input int pw);
        return sf * pw;
    endfunction

    function automatic int wbus_width(input int nk, input int sw, input int pw);
        return nk * sw * pw;
    endfunction

    localparam int DEF_N_KERNEL      = 4;
    localparam int DEF_SF            = 2;
    localparam int DEF_SW            = 3;
    localparam int DEF_PIX_WIDTH     = 16;
    localparam int DEF_CH_WIDTH      = 16;
    localparam int DEF_PIX_PER_CH    = pix_per_ch(DEF_SF);
    localparam int DEF_LOADS_PER_CH  = loads_per_ch(DEF_SF, DEF_SW);
    localparam int DEF_COL_W         = col_width(DEF_SF, DEF_PIX_WIDTH);
    localparam int DEF_WBUS_W        = wbus_width(DEF_N_KERNEL, DEF_SW, DEF_PIX_WIDTH);

endpackage

// File: rtl/deconv_feat_pingpong.sv
// deconv_feat_pingpong
//   Two feature-map banks of SF*SF pixels, written alternately in column-major
//   order. A bank turns FULL the cycle after its last pixel and stays FULL until
//   the reader releases it.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_wr_en, i_wr_data  accepted pixel (already gated by the caller)
//   i_rel, i_rd_bank    release the given read bank (clears its FULL flag)
//   i_rd_col            column to present on o_rd_col
//   o_wr_full           FULL flag of the current write bank
//   o_rd_full           FULL flag of i_rd_bank
//   o_wr_last           this write completes the write bank
//   o_rd_col            column i_rd_col of bank i_rd_bank, row r at [r*PIX_WIDTH +: PIX_WIDTH]
module deconv_feat_pingpong
    import deconv_pkg::*;
#(
    parameter  int SF        = DEF_SF,
    parameter  int PIX_WIDTH = DEF_PIX_WIDTH,
    localparam int PPC       = pix_per_ch(SF),
    localparam int PTR_W     = cnt_width(PPC),
    localparam int CW        = cnt_width(SF)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_wr_en,
    input  logic [PIX_WIDTH-1:0]    i_wr_data,
    input  logic                    i_rel,
    input  logic                    i_rd_bank,
    input  logic [CW-1:0]           i_rd_col,
    output logic                    o_wr_full,
    output logic                    o_rd_full,
    output logic                    o_wr_last,
    output logic [SF*PIX_WIDTH-1:0] o_rd_col
);

    logic [PIX_WIDTH-1:0] bank_mem [2][PPC];
    logic [PTR_W-1:0]     wr_ptr;
    logic                 wr_bank;
    logic [1:0]           full;

    assign o_wr_last = i_wr_en && (wr_ptr == PTR_W'(PPC - 1));
    assign o_wr_full = full[wr_bank];
    assign o_rd_full = full[i_rd_bank];

    // NOTE: bank storage has no reset; the FULL flags gate every read, so stale
    // contents are never consumed and the array can stay plain flops/RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            bank_mem[wr_bank][wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
            full    <= 2'b00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            if (i_wr_en) begin
                if (o_wr_last) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
            end
            // A completing write targets a non-FULL bank and a release targets a
            // FULL one, so the two never hit the same bit in one cycle.
            for (int b = 0; b < 2; b++) begin
                if (o_wr_last && (wr_bank == 1'(b))) begin
                    full[b] <= 1'b1;
                end else if (i_rel && (i_rd_bank == 1'(b))) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        // NOTE: default the whole output first so no path leaves it unassigned
        // (an unassigned path in always_comb infers a latch).
        o_rd_col = '0;
        for (int r = 0; r < SF; r++) begin
            o_rd_col[r*PIX_WIDTH +: PIX_WIDTH] =
                bank_mem[i_rd_bank][PTR_W'(int'(i_rd_col) * SF + r)];
        end
    end

endmodule

// File: rtl/deconv_sched_nk.sv
// deconv_sched_nk
//   Buffers one feature-map channel at a time in a ping-pong store and feeds
//   (feature column x weight column) pairs to N_KERNEL lockstep cores, popping,
//   rewinding and advancing the per-kernel weight FIFOs.
// Ports:
//   i_clk, i_rst_n                   clock, async active-low reset
//   i_start, i_cfg_channels          job start pulse and channel count
//   o_busy, o_done                   job in progress / one-cycle completion pulse
//   i_feat_valid, i_feat_data        feature reader stream (column-major)
//   o_feat_en                        feature reader request
//   i_wfifo_valid, i_wfifo_data      weight FIFO heads, kernel k at slice k
//   o_wfifo_rd_en/_loop/_flush       FIFO pop / rewind / advance pulses
//   i_core_ready                     cores accept a load
//   o_core_load, o_core_new_chnl     load strobe, first load of a channel
//   o_core_feature_col/_weight_col   registered column buses
module deconv_sched_nk
    import deconv_pkg::*;
#(
    parameter int N_KERNEL        = DEF_N_KERNEL,
    parameter int SIZE_OF_FEATURE = DEF_SF,
    parameter int SIZE_OF_WEIGHT  = DEF_SW,
    parameter int PIX_WIDTH       = DEF_PIX_WIDTH,
    parameter int CH_WIDTH        = DEF_CH_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [CH_WIDTH-1:0]       i_cfg_channels,
    output logic                      o_busy,
    output logic                      o_done,
    input  logic                      i_feat_valid,
    input  logic [PIX_WIDTH-1:0]      i_feat_data,
    output logic                      o_feat_en,
    input  logic                      i_wfifo_valid,
    input  logic [wbus_width(N_KERNEL, SIZE_OF_WEIGHT, PIX_WIDTH)-1:0] i_wfifo_data,
    output logic [N_KERNEL-1:0]       o_wfifo_rd_en,
    output logic [N_KERNEL-1:0]       o_wfifo_loop,
    output logic [N_KERNEL-1:0]       o_wfifo_flush,
    input  logic                      i_core_ready,
    output logic                      o_core_load,
    output logic                      o_core_new_chnl,
    output logic [col_width(SIZE_OF_FEATURE, PIX_WIDTH)-1:0] o_core_feature_col,
    output logic [wbus_width(N_KERNEL, SIZE_OF_WEIGHT, PIX_WIDTH)-1:0] o_core_weight_col
);

    localparam int SF     = SIZE_OF_FEATURE;
    localparam int SW     = SIZE_OF_WEIGHT;
    localparam int COL_W  = col_width(SF, PIX_WIDTH);
    localparam int CW     = cnt_width(SF);
    localparam int WW     = cnt_width(SW);

    rd_state_e         state;
    logic [CH_WIDTH-1:0] cfg_q;
    logic [CH_WIDTH-1:0] ch_cnt;      // channels fully issued
    logic [CH_WIDTH-1:0] ch_written;  // channels fully written into the banks
    logic [CW-1:0]     c_cnt;
    logic [WW-1:0]     w_cnt;
    logic              rd_bank;

    logic              wr_en;
    logic              wr_last;
    logic              wr_full;
    logic              rd_full;
    logic              fire;
    logic              last_pair;
    logic              start_acc;
    logic [COL_W-1:0]  rd_col;

    assign o_feat_en = o_busy && !wr_full && (ch_written < cfg_q);
    assign wr_en     = o_feat_en && i_feat_valid;
    assign fire      = (state == RD_ISSUE) && i_wfifo_valid && i_core_ready;
    assign last_pair = (c_cnt == CW'(SF - 1)) && (w_cnt == WW'(SW - 1));
    // DONE accepts a new start as well: o_busy is already low there.
    assign start_acc = i_start && ((state == RD_IDLE) || (state == RD_DONE));

    deconv_feat_pingpong #(
        .SF        (SF),
        .PIX_WIDTH (PIX_WIDTH)
    ) u_pingpong (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (wr_en),
        .i_wr_data (i_feat_data),
        .i_rel     (fire && last_pair),
        .i_rd_bank (rd_bank),
        .i_rd_col  (c_cnt),
        .o_wr_full (wr_full),
        .o_rd_full (rd_full),
        .o_wr_last (wr_last),
        .o_rd_col  (rd_col)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state              <= RD_IDLE;
            cfg_q              <= '0;
            ch_cnt             <= '0;
            ch_written         <= '0;
            c_cnt              <= '0;
            w_cnt              <= '0;
            rd_bank            <= 1'b0;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
            o_core_load        <= 1'b0;
            o_core_new_chnl    <= 1'b0;
            o_wfifo_rd_en      <= '0;
            o_wfifo_loop       <= '0;
            o_wfifo_flush      <= '0;
            o_core_feature_col <= '0;
            o_core_weight_col  <= '0;
        end else begin
            // Strobes are single-cycle; the column buses hold their last load.
            o_done          <= 1'b0;
            o_core_load     <= 1'b0;
            o_core_new_chnl <= 1'b0;
            o_wfifo_rd_en   <= '0;
            o_wfifo_loop    <= '0;
            o_wfifo_flush   <= '0;

            if (start_acc) begin
                ch_written <= '0;
            end else if (wr_last) begin
                ch_written <= ch_written + CH_WIDTH'(1);
            end

            case (state)
                RD_IDLE, RD_DONE: begin
                    state <= RD_IDLE;
                    if (start_acc) begin
                        state  <= RD_WAIT_BANK;
                        o_busy <= 1'b1;
                        cfg_q  <= i_cfg_channels;
                        ch_cnt <= '0;
                        c_cnt  <= '0;
                        w_cnt  <= '0;
                    end
                end

                RD_WAIT_BANK: begin
                    // Checked first so a zero-channel job finishes without a bank.
                    if (ch_cnt == cfg_q) begin
                        state  <= RD_DONE;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end else if (rd_full) begin
                        state <= RD_ISSUE;
                    end
                end

                RD_ISSUE: begin
                    if (fire) begin
                        state              <= RD_STEP;
                        o_core_load        <= 1'b1;
                        o_core_feature_col <= rd_col;
                        o_core_weight_col  <= i_wfifo_data;
                        o_wfifo_rd_en      <= '1;
                        o_core_new_chnl    <= (c_cnt == '0) && (w_cnt == '0);
                        if (w_cnt == WW'(SW - 1)) begin
                            w_cnt <= '0;
                            if (c_cnt == CW'(SF - 1)) begin
                                c_cnt         <= '0;
                                o_wfifo_flush <= '1;
                                rd_bank       <= ~rd_bank;
                                ch_cnt        <= ch_cnt + CH_WIDTH'(1);
                            end else begin
                                c_cnt        <= c_cnt + CW'(1);
                                o_wfifo_loop <= '1;
                            end
                        end else begin
                            w_cnt <= w_cnt + WW'(1);
                        end
                    end
                end

                RD_STEP: begin
                    // The flush strobe is still visible here and marks a channel end.
                    if (o_wfifo_flush[0]) begin
                        if (ch_cnt == cfg_q) begin
                            state  <= RD_DONE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            state <= RD_WAIT_BANK;
                        end
                    end else begin
                        state <= RD_ISSUE;
                    end
                end

                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deconv_sched_nk.sv
// tb_deconv_sched_nk
//   Randomized self-checking bench. The reference model is a job-level view:
//   the expected load sequence is enumerated from channel/column/weight loop
//   order, feature columns come from the pixel stream fed in, weight columns
//   come from a modelled FIFO indexed by pop count, and bank occupancy is
//   channels written minus channels flushed.
module tb_deconv_sched_nk;
    import deconv_pkg::*;

    localparam int NK   = DEF_N_KERNEL;
    localparam int SF   = DEF_SF;
    localparam int SW   = DEF_SW;
    localparam int PW   = DEF_PIX_WIDTH;
    localparam int CHW  = DEF_CH_WIDTH;
    localparam int SPP  = DEF_PIX_PER_CH;
    localparam int LPC  = DEF_LOADS_PER_CH;
    localparam int COLW = DEF_COL_W;
    localparam int WBW  = DEF_WBUS_W;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_start;
    logic [CHW-1:0]  i_cfg_channels;
    logic            o_busy;
    logic            o_done;
    logic            i_feat_valid;
    logic [PW-1:0]   i_feat_data;
    logic            o_feat_en;
    logic            i_wfifo_valid;
    logic [WBW-1:0]  i_wfifo_data;
    logic [NK-1:0]   o_wfifo_rd_en;
    logic [NK-1:0]   o_wfifo_loop;
    logic [NK-1:0]   o_wfifo_flush;
    logic            i_core_ready;
    logic            o_core_load;
    logic            o_core_new_chnl;
    logic [COLW-1:0] o_core_feature_col;
    logic [WBW-1:0]  o_core_weight_col;

    always #5 i_clk = ~i_clk;

    deconv_sched_nk dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_start            (i_start),
        .i_cfg_channels     (i_cfg_channels),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .i_feat_valid       (i_feat_valid),
        .i_feat_data        (i_feat_data),
        .o_feat_en          (o_feat_en),
        .i_wfifo_valid      (i_wfifo_valid),
        .i_wfifo_data       (i_wfifo_data),
        .o_wfifo_rd_en      (o_wfifo_rd_en),
        .o_wfifo_loop       (o_wfifo_loop),
        .o_wfifo_flush      (o_wfifo_flush),
        .i_core_ready       (i_core_ready),
        .o_core_load        (o_core_load),
        .o_core_new_chnl    (o_core_new_chnl),
        .o_core_feature_col (o_core_feature_col),
        .o_core_weight_col  (o_core_weight_col)
    );

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0]  pix  [256];
    logic [WBW-1:0] wmem [256];

    // model state
    int pix_idx, pop_cnt, load_cnt, flush_cnt, loop_cnt, done_cnt, job_cyc, cfg_cur;
    bit in_job, start_pending, acc_pend, pop_pend;
    // stimulus knobs
    int vpct, fpct, rpct, hold_pix, hold_len, hold_cnt;
    int stall_at, stall_left, stall_base, restart_at, rst_at;
    bit stalling, stall_done, restart_done;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {o_busy, o_done, o_feat_en, o_core_load, o_core_new_chnl,
                    o_wfifo_rd_en, o_wfifo_loop, o_wfifo_flush,
                    o_core_feature_col, o_core_weight_col}, '0);
    endtask

    task automatic check_load();
        int ch, k, c, w;
        logic [COLW-1:0] exp_col;
        logic [NK-1:0]   ones;
        ones = '1;
        ch = load_cnt / LPC;
        k  = load_cnt % LPC;
        c  = k / SW;
        w  = k % SW;
        for (int r = 0; r < SF; r++) begin
            exp_col[r*PW +: PW] = pix[(ch*SPP + c*SF + r) & 255];
        end
        if (load_cnt == 0) begin
            check("first_load_min_lat", job_cyc >= SPP + 3, 1);
            if (vpct == 100 && fpct == 100 && rpct == 100)
                check("first_load_lat", job_cyc, SPP + 3);
        end
        check("feature_col", o_core_feature_col, exp_col);
        check("weight_col", o_core_weight_col, wmem[pop_cnt & 255]);
        check("bank_filled", pix_idx >= (ch + 1) * SPP, 1);
        check("rd_en", o_wfifo_rd_en, ones);
        check("new_chnl", o_core_new_chnl, k == 0);
        check("loop", o_wfifo_loop, (w == SW-1 && c < SF-1) ? ones : NK'(0));
        check("flush", o_wfifo_flush, (k == LPC-1) ? ones : NK'(0));
        if (o_wfifo_flush[0]) flush_cnt++;
        if (o_wfifo_loop[0]) loop_cnt++;
        load_cnt++;
    endtask

    // One clock: model the edge, compare outputs, then drive the next inputs.
    task automatic step();
        int occ;
        bit exp_en;
        @(posedge i_clk);
        #1;
        if (acc_pend) pix_idx++;
        if (pop_pend) pop_cnt++;
        if (start_pending) begin
            in_job = 1'b1;
            start_pending = 1'b0;
            job_cyc = 0;
        end
        job_cyc++;

        if (o_core_load) check_load();
        else check("idle_strobes", {o_wfifo_rd_en, o_wfifo_loop, o_wfifo_flush, o_core_new_chnl}, '0);

        if (o_done) begin
            done_cnt++;
            in_job = 1'b0;
            check("done_loads", load_cnt, cfg_cur * LPC);
            check("done_flushes", flush_cnt, cfg_cur);
            check("done_loops", loop_cnt, cfg_cur * (SF - 1));
            if (cfg_cur == 0) check("done_zero_lat", job_cyc, 2);
        end
        check("busy", o_busy, in_job);

        occ = pix_idx / SPP - flush_cnt;
        exp_en = in_job && (occ < 2) && (pix_idx / SPP < cfg_cur);
        check("feat_en", o_feat_en, exp_en);

        if (stalling && stall_left == 0) begin
            check("stall_no_load", load_cnt, stall_base);
            stalling = 1'b0;
        end
        if (!stall_done && stall_at >= 0 && load_cnt == stall_at) begin
            stalling = 1'b1;
            stall_done = 1'b1;
            stall_left = 10;
            stall_base = load_cnt;
        end

        // drive
        if (hold_len > 0 && pix_idx >= hold_pix && hold_cnt < hold_len) begin
            i_feat_valid = 1'b0;
            hold_cnt++;
        end else begin
            i_feat_valid = ($urandom_range(99) < vpct);
        end
        i_feat_data   = pix[pix_idx & 255];
        i_wfifo_valid = ($urandom_range(99) < fpct);
        i_wfifo_data  = wmem[pop_cnt & 255];
        if (stalling) begin
            i_core_ready = 1'b0;
            stall_left--;
        end else begin
            i_core_ready = ($urandom_range(99) < rpct);
        end
        if (!restart_done && restart_at >= 0 && load_cnt == restart_at) begin
            i_start = 1'b1;
            i_cfg_channels = CHW'(5);
            restart_done = 1'b1;
        end else begin
            i_start = 1'b0;
        end
        acc_pend = o_feat_en && i_feat_valid;
        pop_pend = o_wfifo_rd_en[0];
    endtask

    task automatic run_job(input int cfg, input bit incr_pix);
        int guard;
        for (int i = 0; i < 256; i++) pix[i] = incr_pix ? PW'(i + 1) : PW'($urandom);
        pix_idx = 0; load_cnt = 0; flush_cnt = 0; loop_cnt = 0; done_cnt = 0;
        hold_cnt = 0; stalling = 1'b0; stall_done = 1'b0; restart_done = 1'b0;
        cfg_cur = cfg;
        i_cfg_channels = CHW'(cfg);
        i_start = 1'b1;
        start_pending = 1'b1;
        guard = 0;
        step();
        while (in_job && guard < 2000) begin
            if (rst_at >= 0 && load_cnt == rst_at) begin
                #2 i_rst_n = 1'b0;
                #1 check_all_zero("reset_async");
                @(posedge i_clk);
                #1 check_all_zero("reset_held");
                i_start = 1'b0;
                @(negedge i_clk);
                i_rst_n = 1'b1;
                in_job = 1'b0; start_pending = 1'b0; acc_pend = 1'b0; pop_pend = 1'b0;
                check("reset_no_done", done_cnt, 0);
                return;
            end
            step();
            guard++;
        end
        check("job_finished", guard < 2000, 1);
        step();
        step();
        check("done_once", done_cnt, 1);
        check("pix_consumed", pix_idx, cfg * SPP);
    endtask

    task automatic set_mode(input int v, input int f, input int r);
        vpct = v; fpct = f; rpct = r;
        hold_pix = 0; hold_len = 0; stall_at = -1; restart_at = -1; rst_at = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < WBW / 32; j++) wmem[i][j*32 +: 32] = $urandom;
        end
        pop_cnt = 0; in_job = 1'b0; start_pending = 1'b0; acc_pend = 1'b0; pop_pend = 1'b0;
        cfg_cur = 0; job_cyc = 0;
        set_mode(100, 100, 100);
        i_rst_n = 1'b0; i_start = 1'b0; i_cfg_channels = '0;
        i_feat_valid = 1'b0; i_feat_data = '0;
        i_wfifo_valid = 1'b0; i_wfifo_data = '0; i_core_ready = 1'b0;
        #1 check_all_zero("reset_state");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        set_mode(100, 100, 100);
        run_job(1, 1'b0);

        set_mode(100, 100, 100);
        restart_at = 7;
        run_job(3, 1'b1);

        set_mode(100, 100, 100);
        stall_at = 2;
        run_job(2, 1'b0);

        set_mode(100, 100, 100);
        hold_pix = SPP; hold_len = 30;
        run_job(2, 1'b0);

        set_mode(100, 100, 100);
        run_job(0, 1'b0);

        set_mode(100, 100, 100);
        rst_at = 4;
        run_job(2, 1'b0);

        set_mode(100, 100, 100);
        run_job(2, 1'b0);

        set_mode(60, 70, 70);
        run_job(4, 1'b0);

        set_mode(40, 50, 80);
        stall_at = 9;
        run_job(3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deconv_sched_nk.md
# deconv_sched_nk

Parametrised successor to the four-core deconvolution controller. It ping-pong buffers one feature-map channel at a time from the feature BRAM reader, then sequences (feature column × weight column) pairs to N_KERNEL deconv_op_top cores. It also drives rewind and advance controls on the per-kernel weight FIFOs. It sits between the BRAM readers / weight FIFOs and the core array, with a runtime channel count and a start/done handshake.

## Interface
- N_KERNEL, 4, number of kernels / cores served in lockstep
- SIZE_OF_FEATURE, 2, feature map edge (SF)
- SIZE_OF_WEIGHT, 3, weight edge (SW)
- PIX_WIDTH, 16, pixel width
- CH_WIDTH, 16, width of channel count
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  start pulse; ignored while o_busy
- i_cfg_channels  in  CH_WIDTH  channels per kernel; sampled at i_start
- o_busy  out  1  high from start until done
- o_done  out  1  one-cycle pulse at job end
- i_feat_valid  in  1  feature pixel valid
- i_feat_data  in  PIX_WIDTH  feature pixel, column-major order
- o_feat_en  out  1  feature reader request; a pixel is written when o_feat_en && i_feat_valid
- i_wfifo_valid  in  1  all N_KERNEL FIFOs present a column
- i_wfifo_data  in  N_KERNEL*SW*PIX_WIDTH  weight columns; kernel k at slice k
- o_wfifo_rd_en  out  N_KERNEL  pop pulse, all bits equal
- o_wfifo_loop  out  N_KERNEL  rewind to first weight column of current channel
- o_wfifo_flush  out  N_KERNEL  discard current channel, advance to next
- i_core_ready  in  1  cores accept a load
- o_core_load  out  1  one-cycle load strobe
- o_core_new_chnl  out  1  high with the first load of each channel
- o_core_feature_col  out  SF*PIX_WIDTH  row r at [r*PIX_WIDTH +: PIX_WIDTH]
- o_core_weight_col  out  N_KERNEL*SW*PIX_WIDTH  captured i_wfifo_data

## Operation
- Writer fills banks 0/1 alternately with SF*SF pixels per channel. Pixel index i maps to column i/SF, row i%SF.
- A bank becomes FULL the cycle after its last write.
- o_feat_en is high while busy, the current write bank is not FULL, and channels written < cfg_channels.
- Reader FSM states and transitions:
  - IDLE -> WAIT_BANK on start.
  - WAIT_BANK -> ISSUE when the read bank is FULL.
  - ISSUE -> STEP when i_wfifo_valid && i_core_ready.
  - STEP -> ISSUE for the next pair, or -> WAIT_BANK / DONE after the last pair of a channel.
  - DONE -> IDLE after one cycle.
- Loop order per channel: feature column c = 0..SF-1 outer, weight column w = 0..SW-1 inner, giving SF*SW loads per channel.
- On an ISSUE fire, the next cycle registers:
  - o_core_load = 1;
  - o_core_feature_col = column c;
  - o_core_weight_col = i_wfifo_data;
  - o_wfifo_rd_en = all ones;
  - o_core_new_chnl = (c==0 && w==0).
- For w == SW-1 && c < SF-1: o_wfifo_loop pulses with that rd_en.
- For w == SW-1 && c == SF-1: o_wfifo_flush pulses with that rd_en, the read bank is released (FULL cleared), and the read bank toggles.
- Channel counter increments on flush. When it equals cfg_channels, go to DONE: o_done pulses and o_busy drops the same cycle.

## Timing
- Reset values:
  - o_busy, o_done, o_feat_en, o_core_load, o_core_new_chnl = 0;
  - o_wfifo_* = 0;
  - column buses = 0.
  - Both banks are EMPTY and the FSM is in IDLE.
- Reset asserted mid-job aborts immediately to the reset state. No done is issued.
- o_busy rises the cycle after i_start.
- The first load comes no earlier than SF*SF+3 cycles after start with a continuously valid reader.
- Throughput is at most one load per 2 cycles (ISSUE/STEP), so the FIFO valid is re-evaluated after each pop.
- Stalls:
  - i_core_ready or i_wfifo_valid low holds ISSUE, with no outputs pulsed.
  - A bank release and a writer completing the other bank in the same cycle are both honoured.
  - If both banks are FULL, o_feat_en is low.
- cfg_channels == 0: o_done pulses 2 cycles after start, with no loads and no feature requests.
- The writer never overwrites a FULL bank. A bank released in cycle t is writable from t+1.

## Structure
- Shared package deconv_pkg:
  - reader state enum (IDLE, WAIT_BANK, ISSUE, STEP, DONE);
  - localparams for pixels per channel (SF*SF), loads per channel (SF*SW), column and bus widths;
  - clog2-based counter widths.
- Sub-module deconv_feat_pingpong holds:
  - the two register banks;
  - the write pointer/bank select;
  - the FULL flags;
  - a combinational column read port (bank, column) -> SF*PIX_WIDTH.
- The top level keeps the reader FSM, the c/w/channel counters and the output registers.

## Test plan
- Default params, cfg_channels=1, reader always valid, FIFO/cores always ready -> 6 loads, rd_en pulses=6, loop=1 (after 3rd load), flush=1 (with 6th), new_chnl only on 1st, one o_done.
- cfg_channels=3, pixels 0x0001.. incrementing -> 18 loads; channel 2 first feature_col = {0x000A,0x0009}; exactly 3 flush pulses; o_feat_en drops after pixel 12.
- i_core_ready held low 10 cycles mid-channel -> no load/rd_en during hold; sequence resumes at same (c,w); totals unchanged.
- Reader stalls so bank 1 fills only after bank 0 released -> reader waits in WAIT_BANK; no load uses unfilled data; o_feat_en low while both banks FULL.
- cfg_channels=0 -> o_done 2 cycles after start, zero loads, o_feat_en never high; i_start during busy is ignored (load count unchanged).
- i_rst_n pulsed after 4th load of a 2-channel job -> all outputs 0 asynchronously; new start runs clean 12-load job.
